tmr_scrub_ctrl: RTL

TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

---
 rtl/tmr_scrub_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Background scrubber for a triplicated register bank: after each idle interval it sweeps every
// address, votes the three copies bitwise and writes the majority back when the copies disagree.
module tmr_scrub_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int TMR_W  = 16
) (
    input  logic              CP,
    input  logic              CDN,
    input  logic              EN,
    input  logic [TMR_W-1:0]  INTERVAL,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_Q1,
    input  logic [DATA_W-1:0] RD_Q2,
    input  logic [DATA_W-1:0] RD_Q3,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic              HOST_REQ,
    output logic              HOST_GNT,
    output logic [TMR_W-1:0]  SEU_CNT,
    input  logic              SEU_CLR,
    output logic              BUSY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;
    localparam logic [2:0] S_PARK  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [TMR_W-1:0]  CNT_MAX   = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  seu_q, seu_d;
    logic [DATA_W-1:0] fix_q, fix_d;

    logic [DATA_W-1:0] maj;
    logic              mismatch;
    logic [TMR_W-1:0]  reload_val;
    logic              gnt;
    logic              adv;

    assign maj        = (RD_Q1 & RD_Q2) | (RD_Q2 & RD_Q3) | (RD_Q3 & RD_Q1);
    assign mismatch   = (RD_Q1 != maj) || (RD_Q2 != maj) || (RD_Q3 != maj);
    // A zero interval still spends one cycle in WAIT so the host always gets a window.
    assign reload_val = (INTERVAL == '0) ? TMR_ONE : INTERVAL;
    assign gnt        = HOST_REQ && ((state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_PARK));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        fix_d   = fix_q;
        adv     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_WAIT;
                    timer_d = reload_val;
                    addr_d  = '0;
                end
            end
            S_WAIT: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end else if (!gnt) begin
                    timer_d = timer_q - TMR_ONE;
                    if (timer_q <= TMR_ONE) begin
                        timer_d = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch) begin
                    state_d = S_FIX;
                    fix_d   = maj;
                end else begin
                    adv = 1'b1;
                end
            end
            S_FIX: begin
                adv = 1'b1;
            end
            S_PARK: begin
                if (!EN) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (!HOST_REQ) begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // Address-advance step: the register just handled is complete, decide where to go next.
        if (adv) begin
            if (!EN) begin
                state_d = S_IDLE;
                addr_d  = '0;
            end else if (addr_q == ADDR_LAST) begin
                state_d = S_WAIT;
                addr_d  = '0;
                timer_d = reload_val;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = HOST_REQ ? S_PARK : S_READ;
            end
        end
    end

    always_comb begin
        seu_d = seu_q;
        if (SEU_CLR) begin
            seu_d = '0;
        end else if ((state_q == S_FIX) && (seu_q != CNT_MAX)) begin
            seu_d = seu_q + TMR_ONE;
        end
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            timer_q <= '0;
            seu_q   <= '0;
            fix_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            seu_q   <= seu_d;
            fix_q   <= fix_d;
        end
    end

    assign RD_ADDR  = addr_q;
    assign WR_EN    = (state_q == S_FIX) && !gnt;
    assign WR_ADDR  = addr_q;
    assign WR_DATA  = fix_q;
    assign HOST_GNT = gnt;
    assign SEU_CNT  = seu_q;
    assign BUSY     = (state_q == S_READ) || (state_q == S_CHECK) || (state_q == S_FIX);

endmodule
